// File: rtl/alarm_time_setter.sv
// Multi-channel BCD HH:MM setter driven by raw active-low minute/hour buttons.
// Step lands on the (SYNC_STAGES+1)th clock edge after the raw button is first sampled low.
// Holding a button auto-repeats; en low forces both buttons idle and blocks all steps.
module alarm_time_setter #(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [SEL_W-1:0]       ch_sel,
  input  logic                   dir,
  input  logic                   push_min,
  input  logic                   push_hr,
  output logic [3:0]             rd_h1,
  output logic [3:0]             rd_h0,
  output logic [3:0]             rd_m1,
  output logic [3:0]             rd_m0,
  output logic [NUM_CH*16-1:0]   all_time,
  output logic                   upd,
  output logic [SEL_W-1:0]       upd_ch
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} btn_state_t;

  // Button index 0 is the minute button, index 1 the hour button.
  logic [1:0]             push_raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] settle_q;
  logic [1:0]             synced;
  logic [1:0]             prev_q;
  logic [1:0]             armed_q;
  logic [1:0]             press;
  logic [1:0]             step;
  btn_state_t             state_q [2];
  btn_state_t             state_d [2];
  logic [CNT_W-1:0]       cnt_q [2];
  logic [CNT_W-1:0]       cnt_d [2];

  logic [15:0]            time_q [NUM_CH];
  logic [15:0]            cur_time;
  logic [15:0]            nxt_time;
  logic                   sel_ok;
  logic                   any_step;

  assign push_raw = {push_hr, push_min};

  // Minute digit step with wrap 59<->00 and no carry into hours.
  function automatic logic [7:0] min_step(input logic [7:0] mm, input logic down);
    logic [3:0] m1;
    logic [3:0] m0;
    m1 = mm[7:4];
    m0 = mm[3:0];
    if (!down) begin
      if (m0 < 4'd9) m0 = m0 + 4'd1;
      else begin
        m0 = 4'd0;
        m1 = (m1 < 4'd5) ? m1 + 4'd1 : 4'd0;
      end
    end else begin
      if (m0 > 4'd0) m0 = m0 - 4'd1;
      else begin
        m0 = 4'd9;
        m1 = (m1 > 4'd0) ? m1 - 4'd1 : 4'd5;
      end
    end
    return {m1, m0};
  endfunction

  // Hour digit step with wrap 23<->00 in 24 h format.
  function automatic logic [7:0] hr_step(input logic [7:0] hh, input logic down);
    logic [3:0] h1;
    logic [3:0] h0;
    h1 = hh[7:4];
    h0 = hh[3:0];
    if (!down) begin
      if (h1 == 4'd2 && h0 == 4'd3) begin
        h1 = 4'd0;
        h0 = 4'd0;
      end else if (h0 == 4'd9) begin
        h1 = h1 + 4'd1;
        h0 = 4'd0;
      end else h0 = h0 + 4'd1;
    end else begin
      if (h1 == 4'd0 && h0 == 4'd0) begin
        h1 = 4'd2;
        h0 = 4'd3;
      end else if (h0 == 4'd0) begin
        h1 = h1 - 4'd1;
        h0 = 4'd9;
      end else h0 = h0 - 4'd1;
    end
    return {h1, h0};
  endfunction

  // Synchronise buttons; arm press detection only after a released level is seen post-reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) sync_q[b] <= '1;
      settle_q <= '0;
      prev_q   <= 2'b11;
      armed_q  <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        sync_q[b]  <= {sync_q[b][SYNC_STAGES-2:0], push_raw[b]};
        prev_q[b]  <= synced[b];
        armed_q[b] <= armed_q[b] | (settle_q[SYNC_STAGES-1] & synced[b]);
      end
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Press is a synced high-to-low transition on an armed button.
  always_comb begin
    synced = 2'b11;
    press  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      synced[b] = sync_q[b][SYNC_STAGES-1];
      press[b]  = armed_q[b] & prev_q[b] & ~synced[b];
    end
  end

  // Button FSM state and hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // Button FSM next state: step on press, after the initial delay, then at the repeat rate.
  always_comb begin
    step = 2'b00;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      if (!en) begin
        state_d[b] = IDLE;
        cnt_d[b]   = '0;
      end else begin
        case (state_q[b])
          IDLE: begin
            if (press[b]) begin
              step[b]    = 1'b1;
              state_d[b] = HOLD;
              cnt_d[b]   = '0;
            end
          end
          HOLD: begin
            if (synced[b]) begin
              state_d[b] = IDLE;
              cnt_d[b]   = '0;
            end else if (cnt_q[b] == DELAY_LAST) begin
              step[b]    = 1'b1;
              state_d[b] = REPEAT;
              cnt_d[b]   = '0;
            end else cnt_d[b] = cnt_q[b] + 1'b1;
          end
          REPEAT: begin
            if (synced[b]) begin
              state_d[b] = IDLE;
              cnt_d[b]   = '0;
            end else if (cnt_q[b] == RATE_LAST) begin
              step[b]  = 1'b1;
              cnt_d[b] = '0;
            end else cnt_d[b] = cnt_q[b] + 1'b1;
          end
          default: begin
            state_d[b] = IDLE;
            cnt_d[b]   = '0;
          end
        endcase
      end
    end
  end

  // Select the addressed channel, read it out and compute its stepped value.
  always_comb begin
    sel_ok   = 1'b0;
    cur_time = 16'h0000;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == SEL_W'(c)) begin
        sel_ok   = 1'b1;
        cur_time = time_q[c];
      end
    end
    {rd_h1, rd_h0, rd_m1, rd_m0} = cur_time;
    nxt_time = cur_time;
    if (step[0]) nxt_time[7:0]  = min_step(cur_time[7:0], dir);
    if (step[1]) nxt_time[15:8] = hr_step(cur_time[15:8], dir);
    any_step = sel_ok & (step[0] | step[1]);
  end

  // Write only the selected channel and flag the update for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) time_q[c] <= 16'h0000;
      upd    <= 1'b0;
      upd_ch <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (any_step && ch_sel == SEL_W'(c)) time_q[c] <= nxt_time;
      end
      upd <= any_step;
      if (any_step) upd_ch <= ch_sel;
    end
  end

  // Flatten all channels for the comparator and display mux.
  always_comb begin
    all_time = '0;
    for (int c = 0; c < NUM_CH; c++) all_time[16*c +: 16] = time_q[c];
  end

endmodule
